prealu_seq: RTL and testbench
=============================

PREALU_SEQ -- requirements
Module: prealu_seq

Interface
REQ-001 The block SHALL have exactly these ports, one per line: name direction width meaning.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 req_valid  input  1  requester presents an operation.
REQ-005 req_ready  output  1  block accepts an operation; transfer when req_valid & req_ready at a rising edge.
REQ-006 req_asrc  input  2  A-side source: 00 DB, 01 ADL, 10 SB, 11 zero (clear A).
REQ-007 req_bsrc  input  2  B-side source: 00 DB, 01 inverted DB, 10 ADL, 11 illegal.
REQ-008 req_op  input  3  ALU operation code, passed through.
REQ-009 req_cin  input  1  ALU carry-in, passed through.
REQ-010 abort  input  1  cancel the in-flight operation.
REQ-011 alu_done  input  1  ALU result-ready pulse.
REQ-012 dbwa, adlwa, sbwa, zwa  output  1 each  A-register load strobes (DB, ADL, SB, zero).
REQ-013 dbwb, dbnwb, adlwb  output  1 each  B-register load strobes (DB, inverted DB, ADL).
REQ-014 alu_op  output  3  captured req_op.
REQ-015 alu_cin  output  1  captured req_cin.
REQ-016 alu_go  output  1  one-cycle ALU start pulse.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 err  output  1  error flag, meaningful only while done=1.
REQ-019 ops_count  output  8  count of error-free completions.

Function
REQ-020 The block SHALL implement states IDLE, LOADA, LOADB, EXEC, WAIT, DONE, all outputs registered or decoded from state and captured fields.
REQ-021 req_ready SHALL be 1 only in IDLE; in IDLE a handshake SHALL capture asrc, bsrc, op, cin and move to LOADA, or to DONE with err=1 and no strobes if req_bsrc=11.
REQ-022 LOADA SHALL assert exactly one A strobe per captured asrc for one cycle, then go to LOADB.
REQ-023 LOADB SHALL assert exactly one B strobe per captured bsrc for one cycle, then go to EXEC.
REQ-024 EXEC SHALL assert alu_go for one cycle, clear the 4-bit wait timer, then go to WAIT.
REQ-025 WAIT SHALL go to DONE with err=0 when alu_done=1; otherwise increment timer; after 15 WAIT cycles without alu_done, go to DONE with err=1.
REQ-026 DONE SHALL assert done for one cycle and return to IDLE; ops_count SHALL increment when err=0, wrapping 255 to 0.
REQ-027 At most one A strobe and one B strobe SHALL be high in any cycle; A and B strobes never high in the same cycle.
REQ-028 alu_op and alu_cin SHALL hold captured values from the cycle after acceptance until return to IDLE, and hold last value in IDLE.
REQ-029 Minimum latency SHALL be: accept edge cycle 0, LOADA cycle 1, LOADB cycle 2, EXEC cycle 3, WAIT cycle 4, done cycle 5 when alu_done=1 in cycle 4.
REQ-030 abort=1 in any non-IDLE state SHALL force IDLE next cycle with no done pulse and no ops_count change; abort in IDLE SHALL be ignored.
REQ-031 abort and alu_done both high in WAIT SHALL resolve as abort.
REQ-032 alu_done outside WAIT SHALL be ignored.
REQ-033 A new request SHALL NOT be accepted in the DONE cycle; earliest next acceptance is the following IDLE cycle.

Reset
REQ-034 reset=1 SHALL force IDLE, all strobes, alu_go, done, err to 0, alu_op=0, alu_cin=0, ops_count=0, timer=0, at the next rising edge.
REQ-035 reset SHALL take priority over abort, handshake and alu_done, including mid-operation.

Verification
REQ-036 asrc=01, bsrc=00, op=3, cin=1, alu_done in first WAIT cycle -> adlwa cycle 1, dbwb cycle 2, alu_go cycle 3 with alu_op=3, alu_cin=1, done=1 err=0 cycle 5, ops_count=1.
REQ-037 alu_done never asserted -> after 15 WAIT cycles done=1, err=1, ops_count unchanged.
REQ-038 bsrc=11 -> no strobes, no alu_go, done=1 err=1 one cycle after acceptance.
REQ-039 abort in LOADB, then abort with alu_done in WAIT on a second op -> IDLE next cycle each time, no done, ops_count unchanged, req_ready=1.
REQ-040 256 error-free ops -> ops_count wraps to 0; reset asserted during WAIT -> all outputs zero next cycle.

Source files
------------

// File: rtl/prealu_seq.sv
// Pre-ALU sequencer: steers A/B register load strobes, launches the ALU,
// waits (with timeout) for its result and reports completion.
//
// state | meaning
// IDLE  | ready for a request; captures fields on handshake
// LOADA | one A-side load strobe from captured asrc
// LOADB | one B-side load strobe from captured bsrc
// EXEC  | alu_go pulse, wait timer cleared
// WAIT  | waiting for alu_done, timer counts up to the timeout
// DONE  | done pulse, err valid; ops_count bumped on success
module prealu_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_asrc,
  input  logic [1:0] req_bsrc,
  input  logic [2:0] req_op,
  input  logic       req_cin,
  input  logic       abort,
  input  logic       alu_done,
  output logic       dbwa,
  output logic       adlwa,
  output logic       sbwa,
  output logic       zwa,
  output logic       dbwb,
  output logic       dbnwb,
  output logic       adlwb,
  output logic [2:0] alu_op,
  output logic       alu_cin,
  output logic       alu_go,
  output logic       done,
  output logic       err,
  output logic [7:0] ops_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADA = 3'd1,
    LOADB = 3'd2,
    EXEC  = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // WAIT cycles are numbered 0..14 by the timer; the last one times out.
  localparam logic [3:0] TIMER_LAST = 4'd14;

  state_t     state_q, state_d;
  logic [1:0] asrc_q, asrc_d;
  logic [1:0] bsrc_q, bsrc_d;
  logic [2:0] op_q, op_d;
  logic       cin_q, cin_d;
  logic       err_q, err_d;
  logic [3:0] timer_q, timer_d;
  logic [7:0] ops_count_q, ops_count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      asrc_q      <= 2'b00;
      bsrc_q      <= 2'b00;
      op_q        <= 3'd0;
      cin_q       <= 1'b0;
      err_q       <= 1'b0;
      timer_q     <= 4'd0;
      ops_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      asrc_q      <= asrc_d;
      bsrc_q      <= bsrc_d;
      op_q        <= op_d;
      cin_q       <= cin_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
      ops_count_q <= ops_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    asrc_d      = asrc_q;
    bsrc_d      = bsrc_q;
    op_d        = op_q;
    cin_d       = cin_q;
    err_d       = err_q;
    timer_d     = timer_q;
    ops_count_d = ops_count_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          asrc_d = req_asrc;
          bsrc_d = req_bsrc;
          op_d   = req_op;
          cin_d  = req_cin;
          if (req_bsrc == 2'b11) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = LOADA;
          end
        end
      end
      LOADA: state_d = LOADB;
      LOADB: state_d = EXEC;
      EXEC: begin
        timer_d = 4'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (alu_done) begin
          err_d   = 1'b0;
          state_d = DONE;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      DONE: begin
        if (!err_q) begin
          ops_count_d = ops_count_q + 8'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything except reset, including alu_done in WAIT.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      ops_count_d = ops_count_q;
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);

    dbwa  = (state_q == LOADA) && (asrc_q == 2'b00);
    adlwa = (state_q == LOADA) && (asrc_q == 2'b01);
    sbwa  = (state_q == LOADA) && (asrc_q == 2'b10);
    zwa   = (state_q == LOADA) && (asrc_q == 2'b11);

    dbwb  = (state_q == LOADB) && (bsrc_q == 2'b00);
    dbnwb = (state_q == LOADB) && (bsrc_q == 2'b01);
    adlwb = (state_q == LOADB) && (bsrc_q == 2'b10);

    alu_op    = op_q;
    alu_cin   = cin_q;
    alu_go    = (state_q == EXEC);
    done      = (state_q == DONE);
    err       = (state_q == DONE) && err_q;
    ops_count = ops_count_q;
  end

endmodule

// File: tb/tb_prealu_seq.sv
// Directed self-checking bench for prealu_seq: one task per scenario,
// outputs sampled 1 ns after the rising edge.
module tb_prealu_seq;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_asrc;
  logic [1:0] req_bsrc;
  logic [2:0] req_op;
  logic       req_cin;
  logic       abort;
  logic       alu_done;
  logic       dbwa, adlwa, sbwa, zwa;
  logic       dbwb, dbnwb, adlwb;
  logic [2:0] alu_op;
  logic       alu_cin;
  logic       alu_go;
  logic       done;
  logic       err;
  logic [7:0] ops_count;

  logic [6:0] strobes;
  assign strobes = {dbwa, adlwa, sbwa, zwa, dbwb, dbnwb, adlwb};

  int         checks;
  int         failures;
  logic [7:0] exp_ops;

  prealu_seq dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_asrc  (req_asrc),
    .req_bsrc  (req_bsrc),
    .req_op    (req_op),
    .req_cin   (req_cin),
    .abort     (abort),
    .alu_done  (alu_done),
    .dbwa      (dbwa),
    .adlwa     (adlwa),
    .sbwa      (sbwa),
    .zwa       (zwa),
    .dbwb      (dbwb),
    .dbnwb     (dbnwb),
    .adlwb     (adlwb),
    .alu_op    (alu_op),
    .alu_cin   (alu_cin),
    .alu_go    (alu_go),
    .done      (done),
    .err       (err),
    .ops_count (ops_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] a, input logic [1:0] b,
                           input logic [2:0] op, input logic cin);
    req_valid = 1'b1;
    req_asrc  = a;
    req_bsrc  = b;
    req_op    = op;
    req_cin   = cin;
  endtask

  // Full legal operation with alu_done in the first WAIT cycle; ends in IDLE.
  task automatic run_op(input logic [1:0] a, input logic [1:0] b);
    drive_req(a, b, 3'd0, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++;
    if (strobes !== 7'd0) begin failures++; $display("FAIL reset_strobes: got %b expected 0000000", strobes); end
    checks++;
    if ({alu_go, done, err} !== 3'b000) begin failures++; $display("FAIL reset_go_done_err: got %b expected 000", {alu_go, done, err}); end
    checks++;
    if ({alu_op, alu_cin} !== 4'd0) begin failures++; $display("FAIL reset_op_cin: got %h expected 0", {alu_op, alu_cin}); end
    checks++;
    if (ops_count !== 8'd0) begin failures++; $display("FAIL reset_ops_count: got %0d expected 0", ops_count); end
    exp_ops = 8'd0;
  endtask

  task automatic test_basic();
    drive_req(2'b01, 2'b00, 3'd3, 1'b1);
    tick();
    req_valid = 1'b0;
    checks++;
    if (strobes !== 7'b0100000) begin failures++; $display("FAIL basic_c1_adlwa: got %b expected 0100000", strobes); end
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL basic_c1_ready: got %b expected 0", req_ready); end
    tick();
    checks++;
    if (strobes !== 7'b0000100) begin failures++; $display("FAIL basic_c2_dbwb: got %b expected 0000100", strobes); end
    tick();
    checks++;
    if ({alu_go, alu_op, alu_cin} !== 5'b1_011_1) begin failures++; $display("FAIL basic_c3_go: got %b expected 10111", {alu_go, alu_op, alu_cin}); end
    checks++;
    if (strobes !== 7'd0) begin failures++; $display("FAIL basic_c3_strobes: got %b expected 0000000", strobes); end
    tick();
    checks++;
    if ({alu_go, done} !== 2'b00) begin failures++; $display("FAIL basic_c4_wait: got %b expected 00", {alu_go, done}); end
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    checks++;
    if ({done, err} !== 2'b10) begin failures++; $display("FAIL basic_c5_done: got %b expected 10", {done, err}); end
    tick();
    exp_ops = exp_ops + 8'd1;
    checks++;
    if ({done, req_ready} !== 2'b01) begin failures++; $display("FAIL basic_c6_idle: got %b expected 01", {done, req_ready}); end
    checks++;
    if (ops_count !== exp_ops) begin failures++; $display("FAIL basic_ops_count: got %0d expected %0d", ops_count, exp_ops); end
  endtask

  task automatic test_sources();
    logic [6:0] ea, eb;
    logic [2:0] op;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 3; b++) begin
        ea = 7'b1000000 >> a;
        eb = 7'b0000100 >> b;
        op = 3'(a + 2 * b);
        drive_req(2'(a), 2'(b), op, 1'(a));
        tick();
        req_valid = 1'b0;
        checks++;
        if (strobes !== ea) begin failures++; $display("FAIL src_a a=%0d b=%0d: got %b expected %b", a, b, strobes, ea); end
        tick();
        checks++;
        if (strobes !== eb) begin failures++; $display("FAIL src_b a=%0d b=%0d: got %b expected %b", a, b, strobes, eb); end
        tick();
        checks++;
        if ({alu_op, alu_cin} !== {op, 1'(a)}) begin failures++; $display("FAIL src_op a=%0d b=%0d: got %b expected %b", a, b, {alu_op, alu_cin}, {op, 1'(a)}); end
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        tick();
        exp_ops = exp_ops + 8'd1;
      end
    end
    checks++;
    if (ops_count !== exp_ops) begin failures++; $display("FAIL src_ops_count: got %0d expected %0d", ops_count, exp_ops); end
  endtask

  task automatic test_timeout();
    int wait_cycles;
    drive_req(2'b10, 2'b01, 3'd5, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    alu_done = 1'b1;  // EXEC: must be ignored
    tick();
    alu_done = 1'b0;
    wait_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) break;
      wait_cycles++;
      tick();
    end
    checks++;
    if (wait_cycles !== 15) begin failures++; $display("FAIL timeout_wait_cycles: got %0d expected 15", wait_cycles); end
    checks++;
    if ({done, err} !== 2'b11) begin failures++; $display("FAIL timeout_done_err: got %b expected 11", {done, err}); end
    tick();
    checks++;
    if (ops_count !== exp_ops) begin failures++; $display("FAIL timeout_ops_count: got %0d expected %0d", ops_count, exp_ops); end
    checks++;
    if ({req_ready, done, err} !== 3'b100) begin failures++; $display("FAIL timeout_idle: got %b expected 100", {req_ready, done, err}); end
  endtask

  task automatic test_illegal();
    drive_req(2'b00, 2'b11, 3'd6, 1'b1);
    tick();
    req_valid = 1'b0;
    checks++;
    if ({done, err} !== 2'b11) begin failures++; $display("FAIL illegal_done_err: got %b expected 11", {done, err}); end
    checks++;
    if ({strobes, alu_go} !== 8'd0) begin failures++; $display("FAIL illegal_no_strobes: got %b expected 00000000", {strobes, alu_go}); end
    tick();
    checks++;
    if ({req_ready, done, strobes} !== 9'b1_0_0000000) begin failures++; $display("FAIL illegal_idle: got %b expected 100000000", {req_ready, done, strobes}); end
    checks++;
    if (ops_count !== exp_ops) begin failures++; $display("FAIL illegal_ops_count: got %0d expected %0d", ops_count, exp_ops); end
  endtask

  task automatic test_abort();
    drive_req(2'b00, 2'b01, 3'd1, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    abort = 1'b1;  // LOADB
    tick();
    abort = 1'b0;
    checks++;
    if ({req_ready, alu_go, done} !== 3'b100) begin failures++; $display("FAIL abort_loadb: got %b expected 100", {req_ready, alu_go, done}); end
    drive_req(2'b10, 2'b10, 3'd2, 1'b1);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    abort = 1'b1;  // WAIT, together with alu_done
    alu_done = 1'b1;
    tick();
    abort = 1'b0;
    alu_done = 1'b0;
    checks++;
    if ({req_ready, done} !== 2'b10) begin failures++; $display("FAIL abort_wait: got %b expected 10", {req_ready, done}); end
    tick();
    checks++;
    if ({done, err} !== 2'b00) begin failures++; $display("FAIL abort_no_done: got %b expected 00", {done, err}); end
    checks++;
    if (ops_count !== exp_ops) begin failures++; $display("FAIL abort_ops_count: got %0d expected %0d", ops_count, exp_ops); end
    drive_req(2'b11, 2'b10, 3'd4, 1'b0);
    abort = 1'b1;  // IDLE: ignored
    tick();
    abort = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (strobes !== 7'b0001000) begin failures++; $display("FAIL abort_idle_ignored: got %b expected 0001000", strobes); end
    tick();
    checks++;
    if (strobes !== 7'b0000001) begin failures++; $display("FAIL abort_idle_adlwb: got %b expected 0000001", strobes); end
    tick();
    tick();
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    checks++;
    if ({done, err} !== 2'b10) begin failures++; $display("FAIL abort_idle_done: got %b expected 10", {done, err}); end
    tick();
    exp_ops = exp_ops + 8'd1;
    checks++;
    if (ops_count !== exp_ops) begin failures++; $display("FAIL abort_idle_ops_count: got %0d expected %0d", ops_count, exp_ops); end
  endtask

  task automatic test_back_to_back();
    drive_req(2'b00, 2'b01, 3'd7, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    checks++;
    if ({done, req_ready} !== 2'b10) begin failures++; $display("FAIL b2b_done_not_ready: got %b expected 10", {done, req_ready}); end
    drive_req(2'b10, 2'b10, 3'd2, 1'b1);  // presented during DONE
    tick();
    exp_ops = exp_ops + 8'd1;
    checks++;
    if ({req_ready, strobes} !== 8'b1_0000000) begin failures++; $display("FAIL b2b_not_taken_in_done: got %b expected 10000000", {req_ready, strobes}); end
    checks++;
    if (ops_count !== exp_ops) begin failures++; $display("FAIL b2b_ops_count1: got %0d expected %0d", ops_count, exp_ops); end
    tick();
    req_valid = 1'b0;
    checks++;
    if (strobes !== 7'b0010000) begin failures++; $display("FAIL b2b_second_sbwa: got %b expected 0010000", strobes); end
    tick();
    checks++;
    if (strobes !== 7'b0000001) begin failures++; $display("FAIL b2b_second_adlwb: got %b expected 0000001", strobes); end
    tick();
    checks++;
    if ({alu_go, alu_op, alu_cin} !== 5'b1_010_1) begin failures++; $display("FAIL b2b_second_go: got %b expected 10101", {alu_go, alu_op, alu_cin}); end
    tick();
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    tick();
    exp_ops = exp_ops + 8'd1;
    checks++;
    if (ops_count !== exp_ops) begin failures++; $display("FAIL b2b_ops_count2: got %0d expected %0d", ops_count, exp_ops); end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 255; i++) run_op(2'(i % 4), 2'(i % 3));
    checks++;
    if (ops_count !== 8'd255) begin failures++; $display("FAIL wrap_255: got %0d expected 255", ops_count); end
    run_op(2'b01, 2'b10);
    checks++;
    if (ops_count !== 8'd0) begin failures++; $display("FAIL wrap_to_0: got %0d expected 0", ops_count); end
    exp_ops = 8'd0;
  endtask

  task automatic test_reset_mid();
    run_op(2'b00, 2'b00);
    exp_ops = exp_ops + 8'd1;
    checks++;
    if (ops_count !== exp_ops) begin failures++; $display("FAIL rmid_pre_count: got %0d expected %0d", ops_count, exp_ops); end
    drive_req(2'b01, 2'b10, 3'd7, 1'b1);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;  // WAIT, with competing abort and alu_done
    abort = 1'b1;
    alu_done = 1'b1;
    tick();
    reset = 1'b0;
    abort = 1'b0;
    alu_done = 1'b0;
    checks++;
    if ({strobes, alu_go, done, err} !== 10'd0) begin failures++; $display("FAIL rmid_outputs: got %b expected 0000000000", {strobes, alu_go, done, err}); end
    checks++;
    if ({alu_op, alu_cin} !== 4'd0) begin failures++; $display("FAIL rmid_op_cin: got %h expected 0", {alu_op, alu_cin}); end
    checks++;
    if (ops_count !== 8'd0) begin failures++; $display("FAIL rmid_ops_count: got %0d expected 0", ops_count); end
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %b expected 1", req_ready); end
    tick();
    checks++;
    if ({done, alu_go} !== 2'b00) begin failures++; $display("FAIL rmid_stays_idle: got %b expected 00", {done, alu_go}); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_ops   = 8'd0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_asrc  = 2'b00;
    req_bsrc  = 2'b00;
    req_op    = 3'd0;
    req_cin   = 1'b0;
    abort     = 1'b0;
    alu_done  = 1'b0;

    test_reset();
    test_basic();
    test_sources();
    test_timeout();
    test_illegal();
    test_abort();
    test_back_to_back();
    test_wrap();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
